// File: rtl/lcd_bus_monitor.sv
// Passive HD44780 bus receiver: synchronizes RS/E/D, decodes writes on the E fall and
// maintains a ROWS x COLS character shadow buffer. Optional macro: LCD_MON_NIBBLE_EN (4-bit bus mode).
module lcd_bus_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int COLS        = 16,
  parameter int ROWS        = 2
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       lcd_rs,
  input  logic                                       lcd_e,
  input  logic [7:0]                                 lcd_d,
  input  logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] rd_row,
  input  logic [$clog2(COLS)-1:0]                    rd_col,
  output logic [7:0]                                 rd_char,
  output logic                                       char_valid,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] char_row,
  output logic [$clog2(COLS)-1:0]                    char_col,
  output logic                                       cmd_valid,
  output logic [7:0]                                 cmd_code,
  output logic                                       busy,
  output logic                                       overrun
);

  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW    = $clog2(COLS);
  localparam int CELLS = ROWS * COLS;
  localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;

  typedef enum logic [0:0] {S_IDLE, S_CLEAR} state_t;

  // Input synchronizer; RS and D travel alongside E so they line up with the synced strobe.
  logic [SYNC_STAGES-1:0] e_sync_q;
  logic [SYNC_STAGES-1:0] rs_sync_q;
  logic [7:0]             d_sync_q [SYNC_STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_sync_q  <= '0;
      rs_sync_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) d_sync_q[i] <= '0;
    end else begin
      e_sync_q    <= {e_sync_q[SYNC_STAGES-2:0], lcd_e};
      rs_sync_q   <= {rs_sync_q[SYNC_STAGES-2:0], lcd_rs};
      d_sync_q[0] <= lcd_d;
      for (int i = 1; i < SYNC_STAGES; i++) d_sync_q[i] <= d_sync_q[i-1];
    end
  end

  logic       e_s;
  logic       e_prev_q;
  logic       cap_rs_q;
  logic [7:0] cap_d_q;
  logic       strobe;

  assign e_s = e_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_prev_q <= 1'b0;
      cap_rs_q <= 1'b0;
      cap_d_q  <= '0;
    end else begin
      e_prev_q <= e_s;
      if (e_s) begin
        cap_rs_q <= rs_sync_q[SYNC_STAGES-1];
        cap_d_q  <= d_sync_q[SYNC_STAGES-1];
      end
    end
  end

  assign strobe = e_prev_q & ~e_s;

  // Byte-level strobe: in 4-bit mode only the second nibble of a pair produces a byte.
  logic       byte_stb;
  logic       byte_rs;
  logic [7:0] byte_d;

`ifdef LCD_MON_NIBBLE_EN
  logic       nib_mode_q;
  logic       nib_lo_q;
  logic [3:0] nib_hi_q;

  always_comb begin
    byte_stb = strobe;
    byte_rs  = cap_rs_q;
    byte_d   = cap_d_q;
    if (nib_mode_q) begin
      byte_stb = strobe & nib_lo_q;
      byte_d   = {nib_hi_q, cap_d_q[7:4]};
    end
  end
`else
  assign byte_stb = strobe;
  assign byte_rs  = cap_rs_q;
  assign byte_d   = cap_d_q;
`endif

  state_t        state_q;
  logic [AW-1:0] clr_q;
  logic [6:0]    ac_q;
  logic          id_q;
  logic          pend_q;
  logic          pend_rs_q;
  logic [7:0]    pend_d_q;
  logic          busy_q;
  logic          overrun_q;
  logic          char_valid_q;
  logic [RW-1:0] char_row_q;
  logic [CW-1:0] char_col_q;
  logic          cmd_valid_q;
  logic [7:0]    cmd_code_q;

  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic up);
    logic [6:0] r;
    if (up) r = (ac == 7'h27) ? 7'h40 : (ac == 7'h67) ? 7'h00 : ac + 7'd1;
    else    r = (ac == 7'h00) ? 7'h67 : (ac == 7'h40) ? 7'h27 : ac - 7'd1;
    return r;
  endfunction

  function automatic logic [AW-1:0] cell_idx(input logic [6:0] ac);
    return AW'((ac[6] ? COLS : 0) + int'(ac[5:0]));
  endfunction

  // Byte selected for execution this cycle: the pending slot has priority over a new strobe.
  logic          ex_go;
  logic          ex_rs;
  logic [7:0]    ex_d;
  logic          ex_vis;
  logic [6:0]    ac_next;
  logic [AW-1:0] ex_idx;

  always_comb begin
    ex_go = 1'b0;
    ex_rs = byte_rs;
    ex_d  = byte_d;
    if (state_q == S_IDLE) begin
      if (pend_q) begin
        ex_go = 1'b1;
        ex_rs = pend_rs_q;
        ex_d  = pend_d_q;
      end else begin
        ex_go = byte_stb;
      end
    end
    ac_next = ac_step(ac_q, id_q);
    ex_vis  = (int'(ac_q[5:0]) < COLS) && (!ac_q[6] || (ROWS > 1));
    ex_idx  = cell_idx(ac_q);
  end

  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [7:0]    wr_data;

  always_comb begin
    wr_en   = ex_go && ex_rs && ex_vis;
    wr_idx  = ex_idx;
    wr_data = ex_d;
    if (state_q == S_CLEAR) begin
      wr_en   = 1'b1;
      wr_idx  = clr_q;
      wr_data = 8'h20;
    end
  end

  // Control FSM. char_valid / cmd_valid are one-cycle valid pulses with no ready:
  // the consumer must sample them on the cycle they are high; nothing is held or retried.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_CLEAR;
      clr_q        <= '0;
      ac_q         <= 7'h00;
      id_q         <= 1'b1;
      pend_q       <= 1'b0;
      pend_rs_q    <= 1'b0;
      pend_d_q     <= '0;
      busy_q       <= 1'b1;
      overrun_q    <= 1'b0;
      char_valid_q <= 1'b0;
      char_row_q   <= '0;
      char_col_q   <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_code_q   <= '0;
`ifdef LCD_MON_NIBBLE_EN
      nib_mode_q   <= 1'b0;
      nib_lo_q     <= 1'b0;
      nib_hi_q     <= '0;
`endif
    end else begin
      char_valid_q <= 1'b0;
      cmd_valid_q  <= 1'b0;
`ifdef LCD_MON_NIBBLE_EN
      if (strobe && nib_mode_q) begin
        nib_lo_q <= ~nib_lo_q;
        if (!nib_lo_q) nib_hi_q <= cap_d_q[7:4];
      end
`endif
      case (state_q)
        S_CLEAR: begin
          if (byte_stb) begin
            if (!pend_q) begin
              pend_q    <= 1'b1;
              pend_rs_q <= byte_rs;
              pend_d_q  <= byte_d;
            end else begin
              overrun_q <= 1'b1;
            end
          end
          clr_q <= clr_q + AW'(1);
          if (clr_q == AW'(CELLS - 1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            clr_q   <= '0;
          end
        end
        default: begin
          if (pend_q) begin
            pend_q <= byte_stb;
            if (byte_stb) begin
              pend_rs_q <= byte_rs;
              pend_d_q  <= byte_d;
            end
          end
          if (ex_go) begin
            if (ex_rs) begin
              ac_q <= ac_next;
              if (ex_vis) begin
                char_valid_q <= 1'b1;
                char_row_q   <= RW'(ac_q[6]);
                char_col_q   <= ac_q[CW-1:0];
              end
            end else begin
              cmd_valid_q <= 1'b1;
              cmd_code_q  <= ex_d;
              if (ex_d == 8'h01) begin
                ac_q    <= 7'h00;
                id_q    <= 1'b1;
                state_q <= S_CLEAR;
                busy_q  <= 1'b1;
                clr_q   <= '0;
              end else if (ex_d[7:1] == 7'b0000001) begin
                ac_q <= 7'h00;
              end else if (ex_d[7:2] == 6'b000001) begin
                id_q <= ex_d[1];
              end else if (ex_d[7]) begin
                ac_q <= ex_d[6:0];
              end
`ifdef LCD_MON_NIBBLE_EN
              else if (ex_d[7:5] == 3'b001) begin
                if (nib_mode_q == ex_d[4]) begin
                  nib_mode_q <= ~ex_d[4];
                  nib_lo_q   <= 1'b0;
                end
              end
`endif
            end
          end
        end
      endcase
    end
  end

  // Shadow buffer: no reset, the clear sweep initialises it. Read is read-before-write.
  logic [7:0]    mem_q [CELLS];
  logic [AW-1:0] rd_idx;
  logic [7:0]    rd_char_q;

  assign rd_idx = AW'(((ROWS > 1) ? int'(rd_row) * COLS : 0) + int'(rd_col));

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_char_q <= '0;
    else       rd_char_q <= mem_q[rd_idx];
  end

  assign rd_char    = rd_char_q;
  assign char_valid = char_valid_q;
  assign char_row   = char_row_q;
  assign char_col   = char_col_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_code   = cmd_code_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Directed bench for lcd_bus_monitor: vector table of bus writes plus hand sequences
// for the clear sweep, pending slot / overrun, read latency and reset mid-sweep.
module tb_lcd_bus_monitor;

  logic       clk;
  logic       reset;
  logic       lcd_rs;
  logic       lcd_e;
  logic [7:0] lcd_d;
  logic       rd_row;
  logic [3:0] rd_col;
  logic [7:0] rd_char;
  logic       char_valid;
  logic       char_row;
  logic [3:0] char_col;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic       busy;
  logic       overrun;

  lcd_bus_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .lcd_rs     (lcd_rs),
    .lcd_e      (lcd_e),
    .lcd_d      (lcd_d),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_char    (rd_char),
    .char_valid (char_valid),
    .char_row   (char_row),
    .char_col   (char_col),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .busy       (busy),
    .overrun    (overrun)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] exp_q[$];

  function automatic logic [15:0] ev_chr(input logic r, input logic [3:0] c);
    return {4'h1, 3'b000, r, 4'h0, c};
  endfunction

  function automatic logic [15:0] ev_cmd(input logic [7:0] code);
    return {8'h20, code};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic sb_event(input logic [15:0] ev);
    logic [15:0] e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_pulse: got %04h, required none", ev);
    end else begin
      e = exp_q.pop_front();
      if (e !== ev) begin
        n_fail++;
        $display("FAIL pulse: got %04h, required %04h", ev, e);
      end
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (char_valid === 1'b1) sb_event(ev_chr(char_row, char_col));
      if (cmd_valid === 1'b1)  sb_event(ev_cmd(cmd_code));
    end
  end

  // Driver tasks
  task automatic bus_write(input logic rs, input logic [7:0] d);
    @(posedge clk); #1;
    lcd_rs = rs;
    lcd_d  = d;
    lcd_e  = 1'b1;
    repeat (3) @(posedge clk);
    #1 lcd_e = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic read_cell(input logic r, input logic [3:0] c, output logic [7:0] v);
    rd_row = r;
    rd_col = c;
    @(posedge clk);
    @(negedge clk);
    v = rd_char;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic        rs;
    logic [7:0]  d;
    logic [15:0] ev;
    logic        rd_en;
    logic        row;
    logic [3:0]  col;
    logic [7:0]  rd_exp;
  } vec_t;

  localparam int NV = 33;
  vec_t vecs [NV];

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, %0d checks so far", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int         n;
    int         k;

    vecs[0]  = '{1'b0, 8'h80, ev_cmd(8'h80),       1'b0, 1'b0, 4'd0,  8'h00};
    vecs[1]  = '{1'b1, 8'h48, ev_chr(1'b0, 4'd0),  1'b1, 1'b0, 4'd0,  8'h48};
    vecs[2]  = '{1'b1, 8'h69, ev_chr(1'b0, 4'd1),  1'b1, 1'b0, 4'd1,  8'h69};
    vecs[3]  = '{1'b0, 8'hCF, ev_cmd(8'hCF),       1'b0, 1'b0, 4'd0,  8'h00};
    vecs[4]  = '{1'b1, 8'h41, ev_chr(1'b1, 4'd15), 1'b1, 1'b1, 4'd15, 8'h41};
    vecs[5]  = '{1'b1, 8'h42, 16'h0,               1'b1, 1'b1, 4'd0,  8'h20};
    vecs[6]  = '{1'b0, 8'h04, ev_cmd(8'h04),       1'b0, 1'b0, 4'd0,  8'h00};
    vecs[7]  = '{1'b0, 8'h80, ev_cmd(8'h80),       1'b0, 1'b0, 4'd0,  8'h00};
    vecs[8]  = '{1'b1, 8'h5A, ev_chr(1'b0, 4'd0),  1'b1, 1'b0, 4'd0,  8'h5A};
    vecs[9]  = '{1'b1, 8'h31, 16'h0,               1'b0, 1'b0, 4'd0,  8'h00};
    vecs[10] = '{1'b0, 8'hC0, ev_cmd(8'hC0),       1'b0, 1'b0, 4'd0,  8'h00};
    vecs[11] = '{1'b1, 8'h55, ev_chr(1'b1, 4'd0),  1'b1, 1'b1, 4'd0,  8'h55};
    vecs[12] = '{1'b1, 8'h56, 16'h0,               1'b0, 1'b0, 4'd0,  8'h00};
    vecs[13] = '{1'b0, 8'h06, ev_cmd(8'h06),       1'b0, 1'b0, 4'd0,  8'h00};
    vecs[14] = '{1'b0, 8'h8F, ev_cmd(8'h8F),       1'b0, 1'b0, 4'd0,  8'h00};
    vecs[15] = '{1'b1, 8'h57, ev_chr(1'b0, 4'd15), 1'b1, 1'b0, 4'd15, 8'h57};
    vecs[16] = '{1'b1, 8'h58, 16'h0,               1'b1, 1'b0, 4'd0,  8'h5A};
    vecs[17] = '{1'b0, 8'hA7, ev_cmd(8'hA7),       1'b0, 1'b0, 4'd0,  8'h00};
    vecs[18] = '{1'b1, 8'h59, 16'h0,               1'b0, 1'b0, 4'd0,  8'h00};
    vecs[19] = '{1'b1, 8'h5B, ev_chr(1'b1, 4'd0),  1'b1, 1'b1, 4'd0,  8'h5B};
    vecs[20] = '{1'b0, 8'hE7, ev_cmd(8'hE7),       1'b0, 1'b0, 4'd0,  8'h00};
    vecs[21] = '{1'b1, 8'h60, 16'h0,               1'b0, 1'b0, 4'd0,  8'h00};
    vecs[22] = '{1'b1, 8'h61, ev_chr(1'b0, 4'd0),  1'b1, 1'b0, 4'd0,  8'h61};
    vecs[23] = '{1'b0, 8'h0C, ev_cmd(8'h0C),       1'b0, 1'b0, 4'd0,  8'h00};
    vecs[24] = '{1'b1, 8'h62, ev_chr(1'b0, 4'd1),  1'b1, 1'b0, 4'd1,  8'h62};
    vecs[25] = '{1'b0, 8'hB0, ev_cmd(8'hB0),       1'b0, 1'b0, 4'd0,  8'h00};
    vecs[26] = '{1'b1, 8'h63, 16'h0,               1'b0, 1'b0, 4'd0,  8'h00};
    vecs[27] = '{1'b0, 8'h02, ev_cmd(8'h02),       1'b0, 1'b0, 4'd0,  8'h00};
    vecs[28] = '{1'b1, 8'h64, ev_chr(1'b0, 4'd0),  1'b1, 1'b0, 4'd0,  8'h64};
    vecs[29] = '{1'b0, 8'h03, ev_cmd(8'h03),       1'b0, 1'b0, 4'd0,  8'h00};
    vecs[30] = '{1'b1, 8'h65, ev_chr(1'b0, 4'd0),  1'b1, 1'b0, 4'd0,  8'h65};
    vecs[31] = '{1'b0, 8'h07, ev_cmd(8'h07),       1'b0, 1'b0, 4'd0,  8'h00};
    vecs[32] = '{1'b1, 8'h66, ev_chr(1'b0, 4'd1),  1'b1, 1'b0, 4'd1,  8'h66};

    reset  = 1'b1;
    lcd_rs = 1'b0;
    lcd_e  = 1'b0;
    lcd_d  = 8'h00;
    rd_row = 1'b0;
    rd_col = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_char", rd_char, 8'h00);
    check("rst_char_valid", char_valid, 1'b0);
    check("rst_char_row", char_row, 1'b0);
    check("rst_char_col", char_col, 4'd0);
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_cmd_code", cmd_code, 8'h00);
    check("rst_busy", busy, 1'b1);
    check("rst_overrun", overrun, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    count_busy(n);
    check("init_busy_len", n, 32);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 16; c++) begin
        read_cell(r[0], c[3:0], v);
        check($sformatf("clr_r%0dc%0d", r, c), v, 8'h20);
      end
    end
    check("init_overrun", overrun, 1'b0);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].ev != 16'h0) exp_q.push_back(vecs[i].ev);
      bus_write(vecs[i].rs, vecs[i].d);
      check($sformatf("vec%0d_events", i), exp_q.size(), 0);
      if (vecs[i].rd_en) begin
        read_cell(vecs[i].row, vecs[i].col, v);
        check($sformatf("vec%0d_rd", i), v, vecs[i].rd_exp);
      end
    end

    // Read latency: new address shows up exactly one cycle later.
    read_cell(1'b0, 4'd0, v);
    check("rd_lat_a", v, 8'h65);
    @(posedge clk); #1;
    rd_col = 4'd1;
    @(negedge clk);
    check("rd_lat_hold", rd_char, 8'h65);
    @(negedge clk);
    check("rd_lat_new", rd_char, 8'h66);

    // Read-before-write on the cell being written (AC = 0x02).
    rd_row = 1'b0;
    rd_col = 4'd2;
    exp_q.push_back(ev_chr(1'b0, 4'd2));
    fork
      bus_write(1'b1, 8'h77);
      begin
        k = 0;
        @(negedge clk);
        while (char_valid !== 1'b1 && k < 40) begin
          k++;
          @(negedge clk);
        end
        check("rbw_seen", k < 40, 1'b1);
        check("rbw_old", rd_char, 8'h20);
        @(negedge clk);
        check("rbw_new", rd_char, 8'h77);
      end
    join

    // Clear followed by two data bytes during the sweep: one pending, one lost.
    exp_q.push_back(ev_cmd(8'h01));
    exp_q.push_back(ev_chr(1'b0, 4'd0));
    bus_write(1'b0, 8'h01);
    check("clr_busy", busy, 1'b1);
    bus_write(1'b1, 8'h33);
    check("pend_no_overrun", overrun, 1'b0);
    bus_write(1'b1, 8'h34);
    check("overrun_set", overrun, 1'b1);
    count_busy(n);
    check("sweep_done", n < 200, 1'b1);
    repeat (3) @(negedge clk);
    check("pend_events", exp_q.size(), 0);
    read_cell(1'b0, 4'd0, v);
    check("pend_cell00", v, 8'h33);
    read_cell(1'b0, 4'd1, v);
    check("pend_cell01", v, 8'h20);
    read_cell(1'b0, 4'd2, v);
    check("pend_cell02", v, 8'h20);
    check("overrun_sticky", overrun, 1'b1);

    // Reset in the middle of a sweep.
    exp_q.push_back(ev_cmd(8'h01));
    bus_write(1'b0, 8'h01);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst2_busy", busy, 1'b1);
    check("rst2_overrun", overrun, 1'b0);
    check("rst2_cmd_code", cmd_code, 8'h00);
    check("rst2_rd_char", rd_char, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    count_busy(n);
    check("rst2_busy_len", n, 32);
    exp_q.push_back(ev_chr(1'b0, 4'd0));
    bus_write(1'b1, 8'h70);
    exp_q.push_back(ev_chr(1'b0, 4'd1));
    bus_write(1'b1, 8'h71);
    read_cell(1'b0, 4'd0, v);
    check("rst2_cell00", v, 8'h70);
    read_cell(1'b0, 4'd1, v);
    check("rst2_cell01", v, 8'h71);
    check("rst2_events", exp_q.size(), 0);

`ifdef LCD_MON_NIBBLE_EN
    exp_q.push_back(ev_cmd(8'h20));
    bus_write(1'b0, 8'h20);
    exp_q.push_back(ev_cmd(8'h80));
    bus_write(1'b0, 8'h80);
    bus_write(1'b0, 8'h00);
    exp_q.push_back(ev_chr(1'b0, 4'd0));
    bus_write(1'b1, 8'h40);
    check("nib_half_events", exp_q.size(), 1);
    bus_write(1'b1, 8'h10);
    read_cell(1'b0, 4'd0, v);
    check("nib_cell00", v, 8'h41);
    exp_q.push_back(ev_cmd(8'h30));
    bus_write(1'b0, 8'h30);
    bus_write(1'b0, 8'h00);
    exp_q.push_back(ev_chr(1'b0, 4'd1));
    bus_write(1'b1, 8'h72);
    read_cell(1'b0, 4'd1, v);
    check("nib_back_8bit", v, 8'h72);
    check("nib_events", exp_q.size(), 0);
`endif

    repeat (5) @(negedge clk);
    check("final_events", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_bus_monitor.md
Name: lcd_bus_monitor

Overview:
- Passive receiver for the HD44780-style 8-bit LCD bus (RS, E, D[7:0]) that the LCD driver writes.
- Synchronizes the bus into the 50 MHz domain and captures each write on the falling edge of E.
- Decodes the command subset the driver issues and keeps a 2x16 character shadow buffer.
- The server reads the buffer back and forwards it to the desktop simulator, so the host sees exactly what the panel shows.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronizer (minimum 2)
COLS, 16, visible columns per row (power of two, at most 64)
ROWS, 2, visible rows (1 or 2)

Ports:
clk  input  1  system clock (CLOCK_50)
reset  input  1  asynchronous, active-high reset
lcd_rs  input  1  LCD register select (1 = data, 0 = command)
lcd_e  input  1  LCD enable strobe
lcd_d  input  8  LCD data bus
rd_row  input  $clog2(ROWS) (min 1)  shadow buffer read row
rd_col  input  $clog2(COLS)  shadow buffer read column
rd_char  output  8  character at (rd_row, rd_col), registered
char_valid  output  1  one-cycle pulse: character written to a visible cell
char_row  output  $clog2(ROWS) (min 1)  row of the last char_valid
char_col  output  $clog2(COLS)  column of the last char_valid
cmd_valid  output  1  one-cycle pulse: command byte received
cmd_code  output  8  last command byte
busy  output  1  clear sweep in progress
overrun  output  1  sticky: strobe lost while busy with pending slot full; cleared only by reset

Behaviour:
- Reset values:
  - All outputs 0, except busy = 1.
  - Address counter AC = 0x00; entry increment flag ID = 1; pending slot empty.
  - FSM enters CLEAR.
- Synchronizer: lcd_rs, lcd_e and lcd_d pass through SYNC_STAGES flops. RS and D are additionally held in a capture register, loaded every cycle in which synced E = 1.
- Strobe: asserted in cycle N when the previous synced E = 1 and the current synced E = 0. The byte used is the capture register.
- Latency:
  - A pin-level E fall produces a strobe SYNC_STAGES+1 cycles later.
  - Buffer write, AC update and the char_valid / cmd_valid pulse all occur in cycle N+1.
- Address map: row 0 = AC 0x00..0x27; row 1 = AC 0x40..0x67.
  - Visible cell when the column (AC & 0x3F) < COLS and row < ROWS.
  - AC increment wraps 0x27 -> 0x40 and 0x67 -> 0x00.
  - AC decrement wraps 0x00 -> 0x67 and 0x40 -> 0x27.
- RS = 1 (data):
  - Visible cell: write the byte to the buffer and pulse char_valid with char_row / char_col.
  - Non-visible cell: no buffer write, no pulse.
  - In both cases AC steps by +1 (ID = 1) or -1 (ID = 0).
- RS = 0 (command):
  - Every command pulses cmd_valid and loads cmd_code.
  - 0x01: AC = 0, ID = 1, enter CLEAR.
  - 0x02 / 0x03: AC = 0.
  - 0b000001xx: ID = D[1].
  - 1xxxxxxx: AC = D[6:0].
  - All other commands: no internal effect.
  - Set-address with an unmapped value (e.g. 0x30) loads AC as given; following data bytes are dropped until AC wraps into a mapped range.
- FSM IDLE:
  - A strobe is executed directly.
  - If the pending slot is full, it is executed first, and a same-cycle strobe takes its place in the slot.
- FSM CLEAR:
  - Writes 0x20 to cell k at sweep cycle k, for k = 0 .. ROWS*COLS-1, then returns to IDLE.
  - busy = 1 for exactly ROWS*COLS cycles.
  - A strobe during CLEAR goes to the one-entry pending slot; a strobe arriving with the slot full sets overrun and is discarded.
  - A pending 0x01 restarts the sweep from cell 0.
- Read port: rd_char is registered with 1-cycle latency. When a read and a write hit the same cell in the same cycle, the old value is returned (read-before-write).
- Reset asserted mid-sweep or mid-strobe: all state returns to reset values immediately; the sweep restarts after reset deasserts.

Optional Feature:
LCD_MON_NIBBLE_EN
- Defined:
  - Function-set command 0b001xxxxx selects the bus width from D[4]: 0 = 4-bit mode, 1 = 8-bit mode.
  - In 4-bit mode, consecutive strobes are paired (high nibble first, from D[7:4]); only the second strobe is decoded, as one byte.
  - A nibble phase flag resets to "high" on reset and whenever width changes.
  - Pairing RS is the RS of the second strobe.
- Undefined: function set only pulses cmd_valid; the bus is always 8-bit.

Test Plan:
- Reset deasserted, no strobes -> busy high 32 cycles then 0; reading all 32 cells gives 0x20; overrun = 0.
- After sweep, cmd 0x80, then data 0x48, 0x69 -> char_valid at (0,0) then (0,1); rd_char(0,1) = 0x69, one cycle after address applied.
- cmd 0xCF, data 0x41, 0x42 -> (1,15) = 0x41; 0x42 goes to AC 0x50 (non-visible, no char_valid); AC = 0x51.
- cmd 0x04 (ID = 0), cmd 0x80, data 0x5A -> (0,0) = 0x5A, AC = 0x67; next data 0x31 dropped (not visible); AC = 0x66.
- cmd 0x01 immediately followed by data 0x33 and 0x34 during the sweep -> 0x33 held pending and written to (0,0) after the sweep; 0x34 lost, overrun = 1.
- With LCD_MON_NIBBLE_EN: function set 0x20, then RS = 1 nibbles 0x4, 0x1 -> a single char_valid with data 0x41.
